// File: rtl/dec_scan_n.sv
// dec_scan_n: N-to-2^N one-hot decoder with registered outputs and a built-in
// scan sequencer. Direct mode decodes `a` with one cycle of latency; scan mode
// walks the one-hot select through every code, holding each for HOLD cycles.
module dec_scan_n #(
    parameter int N    = 5,
    parameter int HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      a,
    input  logic              start,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              busy,
    output logic              done
);

    localparam int W  = 2**N;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
    localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    y_q;
    logic [N-1:0]    idx_q;
    logic            busy_q;
    logic            done_q;
    logic [CW-1:0]   cnt_q;

    logic [N-1:0]    idx_inc;

    // The shift is done at full output width so no bit of the select is lost.
    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        onehot = {{(W-1){1'b0}}, 1'b1} << i;
    endfunction

    // Next code in the scan; only used when idx_q is below the last code.
    assign idx_inc = idx_q + N'(1);

    // Single FSM: sequencing and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (!mode) begin
                        y_q   <= en ? onehot(a) : '0;
                        idx_q <= a;
                    end else if (start) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                        y_q     <= onehot('0);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        y_q <= '0;
                    end
                end
                SCAN: begin
                    // en low freezes the whole sequence in place.
                    if (en) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (idx_q == IDX_LAST) begin
                                state_q <= DONE;
                                y_q     <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_inc;
                                y_q   <= onehot(idx_inc);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; IDLE picks it up.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    y_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    y_q     <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Testbench for dec_scan_n: one instance with N=5/HOLD=1 and one with
// N=3/HOLD=3, driven from a shared clock and shared control inputs.
module tb_dec_scan_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [4:0]  a;
    logic [2:0]  a3;
    logic        start;
    logic [31:0] y;
    logic [4:0]  idx;
    logic        busy;
    logic        done;
    logic [7:0]  y3;
    logic [2:0]  idx3;
    logic        busy3;
    logic        done3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] y;
        logic [4:0]  idx;
        logic        busy;
        logic        done;
        logic        chk_idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    dec_scan_n #(.N(5), .HOLD(1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .start(start),
        .y(y), .idx(idx), .busy(busy), .done(done)
    );

    dec_scan_n #(.N(3), .HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a3), .start(start),
        .y(y3), .idx(idx3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bit_at(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    function automatic exp_t mk(input logic [31:0] ey, input int ei, input logic eb,
                                input logic ed, input logic ci);
        exp_t r;
        r.y = ey; r.idx = 5'(ei); r.busy = eb; r.done = ed; r.chk_idx = ci;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b1; start = 1'b1; a = 5'd9; a3 = 3'd2;
        tick();
        tick();
        total++;
        if ({y, idx, busy, done} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_n5: got y=%h idx=%0d busy=%b done=%b, want y=0 idx=0 busy=0 done=0",
                     y, idx, busy, done);
        end
        total++;
        if ({y3, idx3, busy3, done3} !== {8'h0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_n3: got y=%h idx=%0d busy=%b done=%b, want y=0 idx=0 busy=0 done=0",
                     y3, idx3, busy3, done3);
        end
        rst = 1'b0; start = 1'b0; mode = 1'b0;
    endtask

    task automatic test_direct();
        mode = 1'b0; en = 1'b1; start = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i < 32) begin
                a = 5'(i);
                exp_q.push_back(mk(bit_at(i), i, 1'b0, 1'b0, 1'b1));
            end else begin
                en = 1'b0; a = 5'd17;
                exp_q.push_back(mk(32'h0, 17, 1'b0, 1'b0, 1'b1));
            end
            tick();
            e = exp_q.pop_front();
            total++;
            if (y !== e.y || busy !== e.busy || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
                bad++;
                $display("FAIL direct step %0d: got y=%h idx=%0d busy=%b done=%b, want y=%h idx=%0d busy=%b done=%b",
                         i, y, idx, busy, done, e.y, e.idx, e.busy, e.done);
            end
        end
        en = 1'b1; start = 1'b0;
    endtask

    task automatic test_full_scan();
        int n;
        mode = 1'b1; en = 1'b1; start = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(bit_at(i), i, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b0, 1'b0));
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (y !== e.y || busy !== e.busy || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
                bad++;
                $display("FAIL full_scan cycle k+%0d: got y=%h idx=%0d busy=%b done=%b, want y=%h idx=%0d busy=%b done=%b",
                         j + 1, y, idx, busy, done, e.y, e.idx, e.busy, e.done);
            end
        end
    endtask

    task automatic test_pause();
        int n;
        mode = 1'b1; en = 1'b1; start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(mk(bit_at(i), i, 1'b1, 1'b0, 1'b1));
            if (i == 7)
                for (int p = 0; p < 5; p++) exp_q.push_back(mk(bit_at(7), 7, 1'b1, 1'b0, 1'b1));
        end
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b1, 1'b0));
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (y !== e.y || busy !== e.busy || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
                bad++;
                $display("FAIL pause cycle k+%0d: got y=%h idx=%0d busy=%b done=%b, want y=%h idx=%0d busy=%b done=%b",
                         j + 1, y, idx, busy, done, e.y, e.idx, e.busy, e.done);
            end
            en = !(j >= 7 && j <= 11);
        end
        en = 1'b1;
        tick();
    endtask

    task automatic test_hold();
        int n;
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0; mode = 1'b1; en = 1'b1; start = 1'b1;
        for (int i = 0; i < 8; i++)
            for (int h = 0; h < 3; h++) exp_q.push_back(mk(bit_at(i), i, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b1, 1'b0));
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            tick();
            start = 1'b0;
            e = exp_q.pop_front();
            total++;
            if ({24'h0, y3} !== e.y || busy3 !== e.busy || done3 !== e.done ||
                (e.chk_idx && {2'b00, idx3} !== e.idx)) begin
                bad++;
                $display("FAIL hold3 cycle %0d: got y=%h idx=%0d busy=%b done=%b, want y=%h idx=%0d busy=%b done=%b",
                         j + 1, y3, idx3, busy3, done3, e.y, e.idx, e.busy, e.done);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; en = 1'b1; start = 1'b1;
        for (int i = 0; i <= 12; i++) exp_q.push_back(mk(bit_at(i), i, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(bit_at(i), i, 1'b1, 1'b0, 1'b1));
        for (int j = 0; j < 18; j++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (y !== e.y || busy !== e.busy || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
                bad++;
                $display("FAIL reset_mid step %0d: got y=%h idx=%0d busy=%b done=%b, want y=%h idx=%0d busy=%b done=%b",
                         j, y, idx, busy, done, e.y, e.idx, e.busy, e.done);
            end
            start = (j == 13);
            rst   = (j == 12);
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; en = 1'b1; start = 1'b1; a = 5'd3;
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(bit_at(i), i, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h0, 0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(bit_at(0), 0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(bit_at(1), 1, 1'b1, 1'b0, 1'b1));
        n = exp_q.size();
        for (int j = 0; j < n; j++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (y !== e.y || busy !== e.busy || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
                bad++;
                $display("FAIL back_to_back cycle k+%0d: got y=%h idx=%0d busy=%b done=%b, want y=%h idx=%0d busy=%b done=%b",
                         j + 1, y, idx, busy, done, e.y, e.idx, e.busy, e.done);
            end
            if (j < 28) begin
                start = j[0];
                mode  = j[1];
                a     = 5'd3;
            end else begin
                start = 1'b1;
                mode  = 1'b1;
            end
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; a = '0; a3 = '0; start = 1'b0;
        test_reset();
        test_direct();
        test_full_scan();
        test_pause();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_scan_n.md
Name: dec_scan_n

Overview:
Parametrised N-to-2^N one-hot decoder with registered outputs and a built-in scan sequencer. Direct mode decodes an applied address with one-cycle latency. Scan mode steps the one-hot output through every code, each held for a programmable number of cycles. It is the next-generation row/select driver for the lab's address-decode chain, replacing the fixed combinational 5-to-32 decoder.

Parameters:
N, 5, address width; output width is 2**N (local, derived).
HOLD, 1, clock cycles each code is held in scan mode; legal range is HOLD >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  global enable: direct mode gates the output; scan mode pauses the sequence.
mode  input  1  0 = direct decode, 1 = scan; sampled only in IDLE.
a  input  N  address for direct decode.
start  input  1  begins a scan when in IDLE with mode=1; level-sampled.
y  output  2**N  registered one-hot (or all-zero) select.
idx  output  N  code currently driven on y.
busy  output  1  high while in SCAN.
done  output  1  one-cycle pulse when a scan completes.

Behaviour:
- Every rising clk edge with rst=1 sets: state=IDLE, y=0, idx=0, busy=0, done=0, hold counter=0. Reset overrides all other inputs, including mid-scan.
- Port reset values: y=0, idx=0, busy=0, done=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE, mode=0 (direct):
  - Each edge: y <= en ? (1<<a) : 0; idx <= a.
  - Latency is exactly 1 cycle. start is ignored.
- IDLE, mode=1, start=0: y <= 0; idx holds.
- IDLE, mode=1, start=1, edge k:
  - Go to SCAN; idx <= 0; y <= 1; hold counter <= 0; busy <= 1.
  - en is not required to start a scan.
- SCAN, en=1:
  - Hold counter increments each edge.
  - When the counter reaches HOLD-1 and idx < 2**N-1: idx <= idx+1; y <= 1<<(idx+1); counter <= 0.
  - When the counter reaches HOLD-1 and idx == 2**N-1: go to DONE; y <= 0; busy <= 0; done <= 1.
- SCAN, en=0: idx, y and the counter freeze; busy stays 1. The sequence resumes exactly where it stopped.
- Ignored during SCAN: start, mode changes and a. No restart occurs.
- DONE: lasts exactly one cycle with done=1 and y=0, then returns to IDLE with done <= 0.
  - A start held high is not acted on in DONE. It is acted on at the next IDLE edge, so back-to-back scans are separated by one DONE cycle and one IDLE cycle.
- Scan cycle count: for HOLD=1, y=1<<i is visible in cycles k+1+i (i = 0..2**N-1) and done is high in cycle k+1+2**N. In general each code is held HOLD cycles, giving HOLD*2**N cycles in SCAN.
- Invariant: y is always one-hot or all-zero.
- Index wrap: idx never wraps inside one scan. The last code is 2**N-1, followed by DONE.
- Width: hold counter width is max(1, clog2(HOLD)). Shift arithmetic is done at width 2**N with no truncation.

Test Plan:
- Reset and direct sweep (N=5, HOLD=1): rst=1 for 2 cycles -> y=0, busy=0, done=0. Then mode=0, en=1, a=0..31, one per cycle -> y=1<<a one cycle later (a=5'd31 -> y=32'h8000_0000). Also apply a=5'd17 with en=0 -> y=0 next cycle.
- Full scan (N=5, HOLD=1): mode=1, start pulsed at edge k -> y=32'h1 at k+1, y=32'h8000_0000 at k+32, done=1 and y=0 at k+33, busy=0 from k+33.
- Pause (N=5, HOLD=1): during a scan, drop en when idx=7 for 5 cycles -> y stays 32'h80 for 5 cycles; total done delay = 33+5 cycles.
- Hold parameter (N=3, HOLD=3): start -> each code held 3 cycles; y=8'h01 for cycles 1-3 and y=8'h80 for cycles 22-24; done at cycle 25.
- Reset mid-scan (N=5): assert rst when idx=12 -> next cycle y=0, idx=0, busy=0, done=0. A new start then scans from idx=0.
- Ignored inputs (N=5): start toggled, mode=0 and a=5'd3 applied during SCAN -> the sequence is unaffected. start held high through DONE -> the next scan begins 2 cycles after done.
